// File: rtl/frame_tick_pkg.sv
// Register map, bit positions and control-register layout shared by the
// frame tick scheduler and its bench.
package frame_tick_pkg;

    localparam logic [1:0] ADDR_COUNT = 2'd0;
    localparam logic [1:0] ADDR_CTRL  = 2'd1;
    localparam logic [1:0] ADDR_STAT  = 2'd2;
    localparam logic [1:0] ADDR_MISS  = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_DIV_LSB    = 4;

    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_OVR_BIT  = 1;

    // Widest divider field the register can hold; instances use DIV_W low bits.
    localparam int DIV_MAX_W = 16;

    typedef struct packed {
        logic [DIV_MAX_W-1:0] div;
        logic                 irq_en;
        logic                 en;
    } ctrl_t;

endpackage

// File: rtl/frame_tick_ctrl_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// one-cycle pulse on each synchronised rising edge.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic [SYNC_STAGES:0]   vld_q, vld_d;
    logic                   rise_q, rise_d;

    // Edges are suppressed until the chain has refilled after reset, so a
    // level that is already high at release does not look like a rise.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        dly_d  = sync_q[SYNC_STAGES-1];
        vld_d  = {vld_q[SYNC_STAGES-1:0], 1'b1};
        rise_d = sync_q[SYNC_STAGES-1] & ~dly_q & vld_q[SYNC_STAGES];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            vld_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            vld_q  <= vld_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/frame_tick_ctrl.sv
// Divides synchronised vsync into game ticks, counts frames for the PIO and
// raises a level interrupt per tick; Avalon-MM slave for control/status.
module frame_tick_ctrl
    import frame_tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int DIV_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [CNT_W-1:0] frame_count
);

    logic             edge_pulse;
    ctrl_t            ctrl_q, ctrl_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             irq_q, irq_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] missed_q, missed_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_en, rd_en, ctrl_wr, stat_wr, miss_wr, tick;
    logic             unused_wdata;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_vsync_edge (
        .clk     (clk),
        .reset   (reset),
        .async_in(vsync),
        .rise    (edge_pulse)
    );

    assign unused_wdata = ^writedata;

    always_comb begin
        wr_en   = chipselect & write;
        rd_en   = chipselect & read;
        ctrl_wr = wr_en && (address == ADDR_CTRL);
        stat_wr = wr_en && (address == ADDR_STAT);
        miss_wr = wr_en && (address == ADDR_MISS);
        // A CONTROL write restarts the divider and swallows a coincident edge.
        tick    = edge_pulse && ctrl_q.en && !ctrl_wr &&
                  (div_cnt_q == ctrl_q.div[DIV_W-1:0]);

        ctrl_d = ctrl_q;
        if (ctrl_wr) begin
            ctrl_d.en     = writedata[CTRL_EN_BIT];
            ctrl_d.irq_en = writedata[CTRL_IRQ_EN_BIT];
            ctrl_d.div    = DIV_MAX_W'(writedata[CTRL_DIV_LSB +: DIV_W]);
        end

        div_cnt_d = div_cnt_q;
        if (ctrl_wr) begin
            div_cnt_d = '0;
        end else if (edge_pulse && ctrl_q.en) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        end

        frame_d = frame_q + CNT_W'(tick);

        // Tick wins over a same-cycle W1C; overrun/missed look at the old pending.
        pend_d = pend_q;
        if (stat_wr && writedata[STAT_PEND_BIT]) pend_d = 1'b0;
        if (tick) pend_d = 1'b1;

        ovr_d = ovr_q;
        if (stat_wr && writedata[STAT_OVR_BIT]) ovr_d = 1'b0;
        if (tick && pend_q) ovr_d = 1'b1;

        missed_d = miss_wr ? '0 : missed_q;
        if (tick && pend_q && (missed_d != '1)) missed_d = missed_d + CNT_W'(1);

        irq_d = pend_d & ctrl_d.irq_en;

        rdata_d = '0;
        if (rd_en) begin
            case (address)
                ADDR_COUNT: rdata_d[CNT_W-1:0] = frame_q;
                ADDR_CTRL: begin
                    rdata_d[CTRL_EN_BIT]                 = ctrl_q.en;
                    rdata_d[CTRL_IRQ_EN_BIT]             = ctrl_q.irq_en;
                    rdata_d[CTRL_DIV_LSB +: DIV_MAX_W]   = ctrl_q.div;
                end
                ADDR_STAT: begin
                    rdata_d[STAT_PEND_BIT] = pend_q;
                    rdata_d[STAT_OVR_BIT]  = ovr_q;
                end
                default: rdata_d[CNT_W-1:0] = missed_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
            div_cnt_q <= '0;
            frame_q   <= '0;
            missed_q  <= '0;
            rdata_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
            div_cnt_q <= div_cnt_d;
            frame_q   <= frame_d;
            missed_q  <= missed_d;
            rdata_q   <= rdata_d;
        end
    end

    assign readdata    = rdata_q;
    assign irq         = irq_q;
    assign frame_count = frame_q;

endmodule
